// File: rtl/audio_sigma_delta_dac_if.sv
// Sample input and pulse-density output bundle for the stereo sigma-delta DAC.
interface audio_sigma_delta_dac_if #(
  parameter int unsigned DW = 16
);
  logic [DW-1:0] audio_l;
  logic [DW-1:0] audio_r;
  logic          audio_stb;
  logic          dac_l;
  logic          dac_r;
  logic          overrun;

  modport master (
    output audio_l, audio_r, audio_stb,
    input  dac_l, dac_r, overrun
  );

  modport slave (
    input  audio_l, audio_r, audio_stb,
    output dac_l, dac_r, overrun
  );
endinterface

// File: rtl/audio_sigma_delta_dac.sv
// Stereo first-order sigma-delta audio DAC with linear interpolation between
// successive sample pairs. Channel index 0 is left, 1 is right.
module audio_sigma_delta_dac #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DIV   = 4,
  parameter int unsigned SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  audio_sigma_delta_dac_if.slave  bus
);
  localparam int unsigned NCH  = 2;
  localparam int unsigned CW   = DW + SHIFT;
  localparam int unsigned CNTW = SHIFT + 1;
  localparam int unsigned DVW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(1) << SHIFT;
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [DVW-1:0]  DIV_LAST = DVW'(DIV - 1);
  localparam logic [CW-1:0]   CUR_MID  = {1'b1, {(CW-1){1'b0}}};

  typedef enum logic {
    S_IDLE,
    S_RAMP
  } state_e;

  logic [DVW-1:0]      div_q, div_d;
  logic                tick;
  state_e              state_q [NCH];
  state_e              state_d [NCH];
  logic [CW-1:0]       cur_q   [NCH];
  logic [CW-1:0]       cur_d   [NCH];
  logic signed [DW:0]  step_q  [NCH];
  logic signed [DW:0]  step_d  [NCH];
  logic [CNTW-1:0]     cnt_q   [NCH];
  logic [CNTW-1:0]     cnt_d   [NCH];
  logic [DW-1:0]       acc_q   [NCH];
  logic [DW-1:0]       acc_d   [NCH];
  logic [NCH-1:0]      dac_q, dac_d;
  logic                overrun_q, overrun_d;
  logic [DW-1:0]       cur_int [NCH];
  logic [DW-1:0]       u_new   [NCH];
  logic [DW:0]         sum     [NCH];

  // Modulator tick divider: counts 0..DIV-1, tick on the last count.
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // Per-channel interpolator FSM and modulator next-state logic.
  always_comb begin
    u_new[0] = {~bus.audio_l[DW-1], bus.audio_l[DW-2:0]};
    u_new[1] = {~bus.audio_r[DW-1], bus.audio_r[DW-2:0]};
    dac_d    = dac_q;
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      cur_int[ch] = cur_q[ch][CW-1:SHIFT];
      state_d[ch] = state_q[ch];
      cur_d[ch]   = cur_q[ch];
      step_d[ch]  = step_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      acc_d[ch]   = acc_q[ch];
      sum[ch]     = {1'b0, acc_q[ch]} + {1'b0, cur_int[ch]};
      // Modulator always sees the pre-update cur_int of this cycle.
      if (tick) begin
        dac_d[ch] = sum[ch][DW];
        acc_d[ch] = sum[ch][DW-1:0];
      end
      // A strobe restarts the ramp from the truncated integer part and
      // suppresses any ramp add that would coincide with it.
      if (bus.audio_stb) begin
        cur_d[ch]   = {cur_int[ch], {SHIFT{1'b0}}};
        step_d[ch]  = {1'b0, u_new[ch]} - {1'b0, cur_int[ch]};
        cnt_d[ch]   = CNT_FULL;
        state_d[ch] = S_RAMP;
      end else if (tick && (state_q[ch] == S_RAMP)) begin
        cur_d[ch] = cur_q[ch] + CW'(step_q[ch]);
        cnt_d[ch] = cnt_q[ch] - 1'b1;
        if (cnt_q[ch] == CNT_ONE) begin
          state_d[ch] = S_IDLE;
        end
      end
    end
    overrun_d = bus.audio_stb && (state_q[0] == S_RAMP);
  end

  // State registers with synchronous reset to midscale.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      dac_q     <= '0;
      overrun_q <= 1'b0;
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        state_q[ch] <= S_IDLE;
        cur_q[ch]   <= CUR_MID;
        step_q[ch]  <= '0;
        cnt_q[ch]   <= '0;
        acc_q[ch]   <= '0;
      end
    end else begin
      div_q     <= div_d;
      dac_q     <= dac_d;
      overrun_q <= overrun_d;
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        state_q[ch] <= state_d[ch];
        cur_q[ch]   <= cur_d[ch];
        step_q[ch]  <= step_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
        acc_q[ch]   <= acc_d[ch];
      end
    end
  end

  assign bus.dac_l   = dac_q[0];
  assign bus.dac_r   = dac_q[1];
  assign bus.overrun = overrun_q;

endmodule
